// File: rtl/vregs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vregs_pkg
// Description : Vector register file geometry and vector-load state encoding.
// Revision    : 1.0
// ============================================================================
package vregs_pkg;

    localparam int NUM_VREGS = 16;
    localparam int VLEN      = 16;
    localparam int ELEM_W    = 16;
    localparam int VREG_W    = VLEN * ELEM_W;
    localparam int VIDX_W    = 4;

    typedef enum logic [1:0] {
        VL_IDLE  = 2'd0,
        VL_FETCH = 2'd1,
        VL_DRAIN = 2'd2,
        VL_WRITE = 2'd3
    } vload_state_e;

endpackage
`default_nettype wire

// File: rtl/vload_agen.sv
`default_nettype none
// ============================================================================
// Module      : vload_agen
// Description : Strided address generator for vector loads; owns addr/idx.
// Revision    : 1.0
// ============================================================================
module vload_agen #(
    parameter int AW = 16,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          step_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] stride_i,
    input  logic [IW-1:0] len_i,
    output logic          mem_ren_o,
    output logic [AW-1:0] mem_raddr_o,
    output logic [IW-1:0] idx_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] idx_q, idx_d;

    // Address arithmetic is plain unsigned AW-bit addition: wrap is silent.
    always_comb begin
        addr_d = addr_q;
        idx_d  = idx_q;
        if (start_i) begin
            addr_d = base_i;
            idx_d  = '0;
        end else if (step_i) begin
            addr_d = addr_q + stride_i;
            idx_d  = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            idx_q  <= '0;
        end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
        end
    end

    assign mem_ren_o   = step_i;
    assign mem_raddr_o = addr_q;
    assign idx_o       = idx_q;
    assign last_o      = (idx_q == len_i);

endmodule
`default_nettype wire

// File: rtl/vload_unit.sv
`default_nettype none
// ============================================================================
// Module      : vload_unit
// Description : Gathers up to NELEM strided elements and writes one vector reg.
// Revision    : 1.0
// ============================================================================
module vload_unit
    import vregs_pkg::*;
#(
    parameter int NELEM = VLEN,
    parameter int EW    = ELEM_W,
    parameter int AW    = 16,
    parameter int RW    = VIDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       req_base,
    input  logic [AW-1:0]       req_stride,
    input  logic [RW-1:0]       req_vd,
    input  logic [3:0]          req_len,
    output logic                mem_ren,
    output logic [AW-1:0]       mem_raddr,
    input  logic [EW-1:0]       mem_rdata,
    output logic                wEn,
    output logic [RW-1:0]       wAddr,
    output logic [3:0]          wLen,
    output logic [NELEM*EW-1:0] wData,
    output logic                busy,
    output logic                done
);

    localparam int IW = 4;

    vload_state_e state_q, state_d;

    logic [AW-1:0]       stride_q;
    logic [RW-1:0]       vd_q;
    logic [IW-1:0]       len_q;
    logic                cap_vld_q;
    logic [IW-1:0]       cap_idx_q;
    logic [NELEM*EW-1:0] buf_q, buf_d;

    logic          accept;
    logic          fetch;
    logic          last;
    logic [IW-1:0] idx;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        wEn       = 1'b0;
        done      = 1'b0;
        fetch     = 1'b0;
        accept    = 1'b0;
        case (state_q)
            VL_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = VL_FETCH;
                end
            end
            VL_FETCH: begin
                fetch = 1'b1;
                if (last) begin
                    state_d = VL_DRAIN;
                end
            end
            VL_DRAIN: begin
                state_d = VL_WRITE;
            end
            VL_WRITE: begin
                wEn     = 1'b1;
                done    = 1'b1;
                state_d = VL_IDLE;
            end
            default: begin
                state_d = VL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= VL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    vload_agen #(
        .AW (AW),
        .IW (IW)
    ) u_agen (
        .clk         (clk),
        .rst         (rst),
        .start_i     (accept),
        .step_i      (fetch),
        .base_i      (req_base),
        .stride_i    (stride_q),
        .len_i       (len_q),
        .mem_ren_o   (mem_ren),
        .mem_raddr_o (mem_raddr),
        .idx_o       (idx),
        .last_o      (last)
    );

    // Read data lags the strobe by one cycle, so the slot index travels with it.
    always_comb begin
        buf_d = buf_q;
        if (accept) begin
            buf_d = '0;
        end else if (cap_vld_q) begin
            for (int i = 0; i < NELEM; i++) begin
                if (cap_idx_q == IW'(i)) begin
                    buf_d[i*EW +: EW] = mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q  <= '0;
            vd_q      <= '0;
            len_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            buf_q     <= '0;
        end else begin
            if (accept) begin
                stride_q <= req_stride;
                vd_q     <= req_vd;
                len_q    <= req_len;
            end
            cap_vld_q <= fetch;
            cap_idx_q <= idx;
            buf_q     <= buf_d;
        end
    end

    assign wAddr = vd_q;
    assign wLen  = len_q;
    assign wData = buf_q;

endmodule
`default_nettype wire

// File: tb/tb_vload_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vload_unit
// Description : Directed self-checking bench for vload_unit.
// Revision    : 1.0
// ============================================================================
module tb_vload_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [15:0]  req_base = '0;
    logic [15:0]  req_stride = '0;
    logic [3:0]   req_vd = '0;
    logic [3:0]   req_len = '0;
    logic         mem_ren;
    logic [15:0]  mem_raddr;
    logic [15:0]  mem_rdata = '0;
    logic         wEn;
    logic [3:0]   wAddr;
    logic [3:0]   wLen;
    logic [255:0] wData;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_bad = 0;

    logic [15:0]  addr_log[$];
    logic [255:0] wd_log[$];
    int           wa_log[$];
    int           wl_log[$];
    int           wc_log[$];

    vload_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_base   (req_base),
        .req_stride (req_stride),
        .req_vd     (req_vd),
        .req_len    (req_len),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .wEn        (wEn),
        .wAddr      (wAddr),
        .wLen       (wLen),
        .wData      (wData),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns addr ^ 0xA5A5 one cycle after the strobe.
    always @(posedge clk) if (mem_ren) mem_rdata <= mem_raddr ^ 16'hA5A5;

    // Write cycle label = the edge that closes it.
    always @(negedge clk) begin
        if (mem_ren) addr_log.push_back(mem_raddr);
        if (wEn) begin
            wd_log.push_back(wData);
            wa_log.push_back(int'(wAddr));
            wl_log.push_back(int'(wLen));
            wc_log.push_back(cyc + 1);
        end
        if (done !== wEn) done_bad++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] b, input logic [15:0] s, input logic [3:0] l,
                         input logic [3:0] v, output int acc);
        acc = -1;
        @(negedge clk);
        req_base = b; req_stride = s; req_len = l; req_vd = v; req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (req_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) check("accept_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_wen(input int n);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (wd_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wen_timeout", 0, 1);
    endtask

    initial begin
        int acc, acc2, n0, nw;

        // Reset state
        @(negedge clk); #1;
        check("rst_ready", req_ready, 1);
        check("rst_ren", mem_ren, 0);
        check("rst_raddr", mem_raddr, 0);
        check("rst_wen", wEn, 0);
        check("rst_waddr", wAddr, 0);
        check("rst_wlen", wLen, 0);
        check("rst_wdata", wData, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic load
        addr_log.delete();
        issue(16'h0100, 16'h0001, 4'd3, 4'd5, acc);
        wait_wen(1);
        check("b_nrd", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check($sformatf("b_addr%0d", i), addr_log[i], 16'h0100 + 16'(i));
        check("b_lat", wc_log[0] - acc, 6);
        check("b_waddr", wa_log[0], 5);
        check("b_wlen", wl_log[0], 3);
        check("b_wdata", wd_log[0], 256'hA4A6_A4A7_A4A4_A4A5);
        @(negedge clk); #1;
        check("b_wen_1cyc", wEn, 0);
        check("b_ready_after", req_ready, 1);

        // Wrap-around
        addr_log.delete();
        issue(16'hFFFE, 16'h0001, 4'd3, 4'd2, acc);
        wait_wen(2);
        check("w_nrd", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("w_addr2", addr_log[2], 16'h0000);
            check("w_addr3", addr_log[3], 16'h0001);
        end
        check("w_wdata", wd_log[1], 256'hA5A4_A5A5_5A5A_5A5B);

        // Full and strided
        addr_log.delete();
        issue(16'h0000, 16'h0010, 4'd15, 4'd15, acc);
        wait_wen(3);
        check("f_nrd", addr_log.size(), 16);
        if (addr_log.size() == 16) check("f_addr15", addr_log[15], 16'h00F0);
        check("f_wdata", wd_log[2],
              256'hA555_A545_A575_A565_A515_A505_A535_A525_A5D5_A5C5_A5F5_A5E5_A595_A585_A5B5_A5A5);
        check("f_wlen", wl_log[2], 15);
        check("f_waddr", wa_log[2], 15);
        check("f_lat", wc_log[2] - acc, 18);

        // Stride 0, single element
        addr_log.delete();
        issue(16'h1234, 16'h0000, 4'd0, 4'd7, acc);
        wait_wen(4);
        check("s0_nrd", addr_log.size(), 1);
        if (addr_log.size() == 1) check("s0_addr", addr_log[0], 16'h1234);
        check("s0_lat", wc_log[3] - acc, 3);
        check("s0_wdata", wd_log[3], 256'hB791);

        // Backpressure: valid held, fields changed after first accept
        @(negedge clk);
        req_base = 16'h0200; req_stride = 16'h0002; req_len = 4'd7; req_vd = 4'd3; req_valid = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        req_base = 16'h0300; req_stride = 16'h0003; req_len = 4'd1; req_vd = 4'd9;
        acc2 = -1;
        for (int k = 0; k < 100; k++) begin
            if (req_ready) begin
                acc2 = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_wen(6);
        check("bp_gap", acc2 - acc, 11);
        check("bp1_lat", wc_log[4] - acc, 10);
        check("bp1_wdata", wd_log[4], 256'hA7AB_A7A9_A7AF_A7AD_A7A3_A7A1_A7A7_A7A5);
        check("bp1_waddr", wa_log[4], 3);
        check("bp1_wlen", wl_log[4], 7);
        check("bp2_wdata", wd_log[5], 256'hA6A6_A6A5);
        check("bp2_waddr", wa_log[5], 9);
        check("bp2_wlen", wl_log[5], 1);

        // Reset mid-FETCH
        n0 = addr_log.size();
        nw = wd_log.size();
        issue(16'h0500, 16'h0001, 4'd15, 4'd4, acc);
        for (int k = 0; k < 50 && addr_log.size() < n0 + 3; k++) begin
            @(negedge clk); #1;
        end
        check("r_pre_buf", wData, 256'hA0A5);
        #1 rst = 1'b1;
        #1;
        check("r_busy", busy, 0);
        check("r_ren", mem_ren, 0);
        check("r_wdata", wData, 0);
        check("r_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("r_no_wen", wd_log.size(), nw);
        issue(16'h0040, 16'h0004, 4'd1, 4'd1, acc);
        wait_wen(nw + 1);
        check("r2_wdata", wd_log[nw], 256'hA5E1_A5E5);
        check("r2_waddr", wa_log[nw], 1);
        check("r2_lat", wc_log[nw] - acc, 4);

        check("done_eq_wen", done_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
